// File: rtl/zap_retire_pkg.sv
// Shared types and constants for the writeback/retire stage: FSM states,
// exception kinds, CPSR mode encodings, vectors and banked register indices.
package zap_retire_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD2,
    S_EXC2
  } state_t;

  typedef enum logic [2:0] {
    EXC_NONE,
    EXC_DABT,
    EXC_IABT,
    EXC_SWI,
    EXC_IRQ,
    EXC_FIQ,
    EXC_UND
  } exc_t;

  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;

  localparam logic [31:0] VEC_UND  = 32'h04;
  localparam logic [31:0] VEC_SWI  = 32'h08;
  localparam logic [31:0] VEC_IABT = 32'h0C;
  localparam logic [31:0] VEC_DABT = 32'h10;
  localparam logic [31:0] VEC_IRQ  = 32'h18;
  localparam logic [31:0] VEC_FIQ  = 32'h1C;

  // Physical indices of the banked link registers and saved status registers.
  localparam int unsigned PHY_FIQ_R14  = 23;
  localparam int unsigned PHY_IRQ_R14  = 25;
  localparam int unsigned PHY_SVC_R14  = 27;
  localparam int unsigned PHY_UND_R14  = 29;
  localparam int unsigned PHY_ABT_R14  = 31;
  localparam int unsigned PHY_FIQ_SPSR = 34;
  localparam int unsigned PHY_IRQ_SPSR = 35;
  localparam int unsigned PHY_SVC_SPSR = 36;
  localparam int unsigned PHY_UND_SPSR = 37;
  localparam int unsigned PHY_ABT_SPSR = 38;

  localparam int unsigned CPSR_I = 7;
  localparam int unsigned CPSR_F = 6;
  localparam int unsigned CPSR_T = 5;

  // Data abort outranks the upstream exception vector {und,fiq,irq,swi,iabt}.
  function automatic exc_t decode_exc(input logic dabt, input logic [4:0] exc);
    if (dabt)         return EXC_DABT;
    else if (exc[3])  return EXC_FIQ;
    else if (exc[2])  return EXC_IRQ;
    else if (exc[0])  return EXC_IABT;
    else if (exc[1])  return EXC_SWI;
    else if (exc[4])  return EXC_UND;
    else              return EXC_NONE;
  endfunction

endpackage

// File: rtl/zap_exc_vector_lut.sv
// Exception kind -> target mode, vector address, banked R14/SPSR index and
// the amount subtracted from PC+8 to form the link value.
module zap_exc_vector_lut
  import zap_retire_pkg::*;
#(
  parameter int unsigned IW = 6
) (
  input  exc_t              exc,
  output logic [4:0]        mode,
  output logic [31:0]       vector,
  output logic [IW-1:0]     r14_index,
  output logic [IW-1:0]     spsr_index,
  output logic [31:0]       lr_offset
);

  always_comb begin
    mode       = MODE_UND;
    vector     = VEC_UND;
    r14_index  = IW'(PHY_UND_R14);
    spsr_index = IW'(PHY_UND_SPSR);
    lr_offset  = 32'd4;
    unique case (exc)
      EXC_DABT: begin
        mode       = MODE_ABT;
        vector     = VEC_DABT;
        r14_index  = IW'(PHY_ABT_R14);
        spsr_index = IW'(PHY_ABT_SPSR);
        lr_offset  = 32'd0;
      end
      EXC_IABT: begin
        mode       = MODE_ABT;
        vector     = VEC_IABT;
        r14_index  = IW'(PHY_ABT_R14);
        spsr_index = IW'(PHY_ABT_SPSR);
      end
      EXC_SWI: begin
        mode       = MODE_SVC;
        vector     = VEC_SWI;
        r14_index  = IW'(PHY_SVC_R14);
        spsr_index = IW'(PHY_SVC_SPSR);
      end
      EXC_IRQ: begin
        mode       = MODE_IRQ;
        vector     = VEC_IRQ;
        r14_index  = IW'(PHY_IRQ_R14);
        spsr_index = IW'(PHY_IRQ_SPSR);
      end
      EXC_FIQ: begin
        mode       = MODE_FIQ;
        vector     = VEC_FIQ;
        r14_index  = IW'(PHY_FIQ_R14);
        spsr_index = IW'(PHY_FIQ_SPSR);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/zap_writeback_retire.sv
// Retire stage: commits ALU/load results over one register-file write port,
// serialises dual-write loads and sequences two-cycle exception entry.
module zap_writeback_retire
  import zap_retire_pkg::*;
#(
  parameter  int unsigned FLAG_WDT = 32,
  parameter  int unsigned PHY_REGS = 46,
  parameter  int unsigned PHY_PC   = 15,
  parameter  int unsigned PHY_RAZ  = 16,
  localparam int unsigned IW       = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_dav_ff,
  input  logic [4:0]          i_exc_ff,
  input  logic [1:0]          i_mem_fault,
  input  logic [31:0]         i_pc_plus_8_ff,
  input  logic [31:0]         i_alu_result_ff,
  input  logic [FLAG_WDT-1:0] i_flags_ff,
  input  logic [IW-1:0]       i_destination_index_ff,
  input  logic [IW-1:0]       i_mem_srcdest_index_ff,
  input  logic                i_mem_load_ff,
  input  logic [31:0]         i_mem_rd_data,
  output logic                o_stall,
  output logic                o_clear_from_writeback,
  output logic                o_rf_wr_en,
  output logic [IW-1:0]       o_rf_wr_index,
  output logic [31:0]         o_rf_wr_data,
  output logic [31:0]         o_pc_ff,
  output logic                o_pc_valid,
  output logic [FLAG_WDT-1:0] o_cpsr_ff
);

  state_t              state, state_nxt;
  exc_t                exc_q, exc_nxt, exc_now, lut_exc;
  logic                pc_pend, pc_pend_nxt;
  logic [31:0]         pc_pend_data, pc_pend_data_nxt;
  logic                wr_en_nxt, redirect;
  logic [IW-1:0]       wr_idx_nxt;
  logic [31:0]         wr_data_nxt, pc_nxt;
  logic [FLAG_WDT-1:0] cpsr_nxt;

  logic [IW-1:0] pc_idx, raz_idx;
  logic          accept, dabt, take_exc, retire, dual;

  logic [4:0]    lut_mode;
  logic [31:0]   lut_vector, lut_lr_offset;
  logic [IW-1:0] lut_r14, lut_spsr;

  assign pc_idx   = IW'(PHY_PC);
  assign raz_idx  = IW'(PHY_RAZ);
  assign accept   = (state == S_IDLE) && !o_clear_from_writeback;
  assign dabt     = i_dav_ff && (i_mem_fault != 2'b00);
  assign exc_now  = decode_exc(dabt, i_exc_ff);
  assign take_exc = accept && (exc_now != EXC_NONE);
  assign retire   = accept && !take_exc && i_dav_ff;
  assign dual     = i_mem_load_ff && (i_destination_index_ff != raz_idx)
                    && (i_mem_srcdest_index_ff != raz_idx);
  assign o_stall  = take_exc || (retire && dual);

  // Second exception cycle looks up the latched kind; first cycle the live one.
  assign lut_exc = (state == S_EXC2) ? exc_q : exc_now;

  zap_exc_vector_lut #(.IW(IW)) u_exc_lut (
    .exc        (lut_exc),
    .mode       (lut_mode),
    .vector     (lut_vector),
    .r14_index  (lut_r14),
    .spsr_index (lut_spsr),
    .lr_offset  (lut_lr_offset)
  );

  always_comb begin
    state_nxt        = state;
    exc_nxt          = exc_q;
    pc_pend_nxt      = pc_pend;
    pc_pend_data_nxt = pc_pend_data;
    wr_en_nxt        = 1'b0;
    wr_idx_nxt       = o_rf_wr_index;
    wr_data_nxt      = o_rf_wr_data;
    cpsr_nxt         = o_cpsr_ff;
    pc_nxt           = o_pc_ff;
    redirect         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (take_exc) begin
          exc_nxt     = exc_now;
          wr_en_nxt   = 1'b1;
          wr_idx_nxt  = lut_r14;
          wr_data_nxt = i_pc_plus_8_ff - lut_lr_offset;
          state_nxt   = S_EXC2;
        end else if (retire) begin
          cpsr_nxt = i_flags_ff;
          if (dual) begin
            wr_idx_nxt  = i_destination_index_ff;
            wr_data_nxt = i_alu_result_ff;
            state_nxt   = S_LOAD2;
          end else if (i_mem_load_ff && (i_mem_srcdest_index_ff != raz_idx)) begin
            wr_idx_nxt  = i_mem_srcdest_index_ff;
            wr_data_nxt = i_mem_rd_data;
          end else begin
            wr_idx_nxt  = i_destination_index_ff;
            wr_data_nxt = i_alu_result_ff;
          end
          wr_en_nxt = (wr_idx_nxt != raz_idx);
        end
      end
      S_LOAD2: begin
        wr_idx_nxt  = i_mem_srcdest_index_ff;
        wr_data_nxt = i_mem_rd_data;
        wr_en_nxt   = (wr_idx_nxt != raz_idx);
        state_nxt   = S_IDLE;
        pc_pend_nxt = 1'b0;
        if (pc_pend) begin
          redirect = 1'b1;
          pc_nxt   = pc_pend_data;
        end
      end
      S_EXC2: begin
        wr_en_nxt        = 1'b1;
        wr_idx_nxt       = lut_spsr;
        wr_data_nxt      = 32'(o_cpsr_ff);
        cpsr_nxt[4:0]    = lut_mode;
        cpsr_nxt[CPSR_I] = 1'b1;
        cpsr_nxt[CPSR_T] = 1'b0;
        if (exc_q == EXC_FIQ) cpsr_nxt[CPSR_F] = 1'b1;
        pc_nxt           = lut_vector;
        redirect         = 1'b1;
        exc_nxt          = EXC_NONE;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A PC write in the first half of a dual write is parked until LOAD2 retires.
    if (wr_en_nxt && (wr_idx_nxt == pc_idx)) begin
      if (state_nxt == S_LOAD2) begin
        pc_pend_nxt      = 1'b1;
        pc_pend_data_nxt = wr_data_nxt & ~32'h1;
      end else begin
        redirect = 1'b1;
        pc_nxt   = wr_data_nxt & ~32'h1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state                  <= S_IDLE;
      exc_q                  <= EXC_NONE;
      pc_pend                <= 1'b0;
      pc_pend_data           <= '0;
      o_clear_from_writeback <= 1'b0;
      o_rf_wr_en             <= 1'b0;
      o_rf_wr_index          <= IW'(PHY_RAZ);
      o_rf_wr_data           <= '0;
      o_pc_ff                <= '0;
      o_pc_valid             <= 1'b0;
      o_cpsr_ff              <= FLAG_WDT'(32'h1D3);
    end else begin
      state                  <= state_nxt;
      exc_q                  <= exc_nxt;
      pc_pend                <= pc_pend_nxt;
      pc_pend_data           <= pc_pend_data_nxt;
      o_clear_from_writeback <= redirect;
      o_rf_wr_en             <= wr_en_nxt;
      o_rf_wr_index          <= wr_idx_nxt;
      o_rf_wr_data           <= wr_data_nxt;
      o_pc_ff                <= pc_nxt;
      o_pc_valid             <= redirect;
      o_cpsr_ff              <= cpsr_nxt;
    end
  end

endmodule

// File: tb/tb_zap_writeback_retire.sv
// Directed bench for zap_writeback_retire with hand-computed expectations.
module tb_zap_writeback_retire;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_dav_ff;
  logic [4:0]  i_exc_ff;
  logic [1:0]  i_mem_fault;
  logic [31:0] i_pc_plus_8_ff;
  logic [31:0] i_alu_result_ff;
  logic [31:0] i_flags_ff;
  logic [5:0]  i_destination_index_ff;
  logic [5:0]  i_mem_srcdest_index_ff;
  logic        i_mem_load_ff;
  logic [31:0] i_mem_rd_data;
  logic        o_stall;
  logic        o_clear_from_writeback;
  logic        o_rf_wr_en;
  logic [5:0]  o_rf_wr_index;
  logic [31:0] o_rf_wr_data;
  logic [31:0] o_pc_ff;
  logic        o_pc_valid;
  logic [31:0] o_cpsr_ff;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] FLAGS = 32'h6000_001F;

  zap_writeback_retire dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_dav_ff               (i_dav_ff),
    .i_exc_ff               (i_exc_ff),
    .i_mem_fault            (i_mem_fault),
    .i_pc_plus_8_ff         (i_pc_plus_8_ff),
    .i_alu_result_ff        (i_alu_result_ff),
    .i_flags_ff             (i_flags_ff),
    .i_destination_index_ff (i_destination_index_ff),
    .i_mem_srcdest_index_ff (i_mem_srcdest_index_ff),
    .i_mem_load_ff          (i_mem_load_ff),
    .i_mem_rd_data          (i_mem_rd_data),
    .o_stall                (o_stall),
    .o_clear_from_writeback (o_clear_from_writeback),
    .o_rf_wr_en             (o_rf_wr_en),
    .o_rf_wr_index          (o_rf_wr_index),
    .o_rf_wr_data           (o_rf_wr_data),
    .o_pc_ff                (o_pc_ff),
    .o_pc_valid             (o_pc_valid),
    .o_cpsr_ff              (o_cpsr_ff)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_dav_ff               = 1'b0;
    i_exc_ff               = 5'b0;
    i_mem_fault            = 2'b0;
    i_pc_plus_8_ff         = 32'h0;
    i_alu_result_ff        = 32'h0;
    i_flags_ff             = FLAGS;
    i_destination_index_ff = 6'd16;
    i_mem_srcdest_index_ff = 6'd16;
    i_mem_load_ff          = 1'b0;
    i_mem_rd_data          = 32'h0;
  endtask

  task automatic alu_op(input logic [5:0] dest, input logic [31:0] res);
    idle_inputs();
    i_dav_ff               = 1'b1;
    i_destination_index_ff = dest;
    i_alu_result_ff        = res;
  endtask

  task automatic load_op(input logic [5:0] dest, input logic [31:0] res,
                         input logic [5:0] sd, input logic [31:0] rd);
    alu_op(dest, res);
    i_mem_load_ff          = 1'b1;
    i_mem_srcdest_index_ff = sd;
    i_mem_rd_data          = rd;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b0, 6'd16, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_write: got %0b/%0d/%h want 0/16/00000000", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    n_checks++;
    if ({o_pc_valid, o_clear_from_writeback, o_pc_ff} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_pc: got %0b/%0b/%h want 0/0/00000000", o_pc_valid, o_clear_from_writeback, o_pc_ff);
    end
    n_checks++;
    if ({o_cpsr_ff, o_stall} !== {32'h1D3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_cpsr_stall: got %h/%0b want 000001d3/0", o_cpsr_ff, o_stall);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_alu;
    alu_op(6'd3, 32'hCAFE_0001);
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_stall: got %0b want 0", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd3, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL alu_write: got %0b/%0d/%h want 1/3/cafe0001", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    n_checks++;
    if ({o_cpsr_ff, o_clear_from_writeback} !== {FLAGS, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_cpsr: got %h/%0b want %h/0", o_cpsr_ff, o_clear_from_writeback, FLAGS);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    alu_op(6'd9, 32'h11);
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd9, 32'h11}) begin
      n_fail++;
      $display("FAIL b2b_first: got %0b/%0d/%h want 1/9/00000011", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    alu_op(6'd16, 32'h22);
    tick();
    n_checks++;
    if (o_rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_raz_dropped: got wr_en %0b want 0", o_rf_wr_en);
    end
    alu_op(6'd15, 32'h3003);
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_pc_valid, o_clear_from_writeback, o_pc_ff} !==
        {1'b1, 6'd15, 1'b1, 1'b1, 32'h3002}) begin
      n_fail++;
      $display("FAIL b2b_pc_write: got %0b/%0d/%0b/%0b/%h want 1/15/1/1/00003002",
               o_rf_wr_en, o_rf_wr_index, o_pc_valid, o_clear_from_writeback, o_pc_ff);
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({o_pc_valid, o_clear_from_writeback} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_pulse_width: got %0b/%0b want 0/0", o_pc_valid, o_clear_from_writeback);
    end
  endtask

  task automatic test_ldr_writeback;
    load_op(6'd2, 32'h1004, 6'd5, 32'hA5);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL ldr_stall_first: got %0b want 1", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd2, 32'h1004}) begin
      n_fail++;
      $display("FAIL ldr_base_write: got %0b/%0d/%h want 1/2/00001004", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ldr_stall_load2: got %0b want 0", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd5, 32'hA5}) begin
      n_fail++;
      $display("FAIL ldr_data_write: got %0b/%0d/%h want 1/5/000000a5", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (o_rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ldr_no_extra_write: got wr_en %0b want 0", o_rf_wr_en);
    end
  endtask

  task automatic test_load_pc;
    load_op(6'd16, 32'h0, 6'd15, 32'h8001);
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ldpc_stall: got %0b want 0", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_pc_valid, o_clear_from_writeback, o_pc_ff} !==
        {1'b1, 6'd15, 1'b1, 1'b1, 32'h8000}) begin
      n_fail++;
      $display("FAIL ldpc_redirect: got %0b/%0d/%0b/%0b/%h want 1/15/1/1/00008000",
               o_rf_wr_en, o_rf_wr_index, o_pc_valid, o_clear_from_writeback, o_pc_ff);
    end
    alu_op(6'd4, 32'hDEAD);
    i_flags_ff = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ldpc_clear_stall: got %0b want 0", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_clear_from_writeback, o_pc_valid, o_cpsr_ff} !== {1'b0, 1'b0, 1'b0, FLAGS}) begin
      n_fail++;
      $display("FAIL ldpc_ignored: got %0b/%0b/%0b/%h want 0/0/0/%h",
               o_rf_wr_en, o_clear_from_writeback, o_pc_valid, o_cpsr_ff, FLAGS);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dual_pc;
    load_op(6'd15, 32'h4001, 6'd5, 32'h77);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL dualpc_stall: got %0b want 1", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_pc_valid, o_clear_from_writeback} !==
        {1'b1, 6'd15, 32'h4001, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dualpc_first: got %0b/%0d/%h/%0b/%0b want 1/15/00004001/0/0",
               o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_pc_valid, o_clear_from_writeback);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_pc_valid, o_clear_from_writeback, o_pc_ff} !==
        {1'b1, 6'd5, 32'h77, 1'b1, 1'b1, 32'h4000}) begin
      n_fail++;
      $display("FAIL dualpc_second: got %0b/%0d/%h/%0b/%0b/%h want 1/5/00000077/1/1/00004000",
               o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_pc_valid, o_clear_from_writeback, o_pc_ff);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_irq;
    alu_op(6'd7, 32'h9999);
    i_exc_ff       = 5'b00100;
    i_pc_plus_8_ff = 32'h108;
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_stall: got %0b want 1", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_clear_from_writeback} !== {1'b1, 6'd25, 32'h104, 1'b0}) begin
      n_fail++;
      $display("FAIL irq_lr: got %0b/%0d/%h/%0b want 1/25/00000104/0",
               o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_clear_from_writeback);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd35, FLAGS}) begin
      n_fail++;
      $display("FAIL irq_spsr: got %0b/%0d/%h want 1/35/%h", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, FLAGS);
    end
    n_checks++;
    if ({o_cpsr_ff, o_pc_ff, o_pc_valid, o_clear_from_writeback} !== {32'h6000_0092, 32'h18, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL irq_entry: got %h/%h/%0b/%0b want 60000092/00000018/1/1",
               o_cpsr_ff, o_pc_ff, o_pc_valid, o_clear_from_writeback);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dabt;
    alu_op(6'd7, 32'h1111);
    i_exc_ff       = 5'b00100;
    i_mem_fault    = 2'b01;
    i_pc_plus_8_ff = 32'h200;
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL dabt_stall: got %0b want 1", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd31, 32'h200}) begin
      n_fail++;
      $display("FAIL dabt_lr: got %0b/%0d/%h want 1/31/00000200", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_index, o_rf_wr_data, o_cpsr_ff} !== {6'd38, 32'h6000_0092, 32'h6000_0097}) begin
      n_fail++;
      $display("FAIL dabt_spsr_cpsr: got %0d/%h/%h want 38/60000092/60000097", o_rf_wr_index, o_rf_wr_data, o_cpsr_ff);
    end
    n_checks++;
    if ({o_pc_ff, o_pc_valid, o_clear_from_writeback} !== {32'h10, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL dabt_vector: got %h/%0b/%0b want 00000010/1/1", o_pc_ff, o_pc_valid, o_clear_from_writeback);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_load2;
    load_op(6'd2, 32'h2000, 6'd6, 32'hBEEF);
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd2, 32'h2000}) begin
      n_fail++;
      $display("FAIL rst_l2_first: got %0b/%0d/%h want 1/2/00002000", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_cpsr_ff} !== {1'b0, 6'd16, 32'h0, 32'h1D3}) begin
      n_fail++;
      $display("FAIL rst_l2_async: got %0b/%0d/%h/%h want 0/16/00000000/000001d3",
               o_rf_wr_en, o_rf_wr_index, o_rf_wr_data, o_cpsr_ff);
    end
    idle_inputs();
    tick();
    i_reset = 1'b0;
    tick();
    n_checks++;
    if (o_rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_l2_no_second: got wr_en %0b want 0", o_rf_wr_en);
    end
    alu_op(6'd8, 32'h55);
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_l2_idle_stall: got %0b want 0", o_stall);
    end
    tick();
    n_checks++;
    if ({o_rf_wr_en, o_rf_wr_index, o_rf_wr_data} !== {1'b1, 6'd8, 32'h55}) begin
      n_fail++;
      $display("FAIL rst_l2_resume: got %0b/%0d/%h want 1/8/00000055", o_rf_wr_en, o_rf_wr_index, o_rf_wr_data);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_ldr_writeback();
    test_load_pc();
    test_dual_pc();
    test_irq();
    test_dabt();
    test_reset_mid_load2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
